// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (IDLE/IF/ID/EX/MEM/WB) with memory handshake.
// Optional performance counters enabled by MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [6:0]  opcode_i,
    input  logic        mem_ack_i,
    output logic        mem_req_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        PCWrite_o,
    output logic        IRWrite_o,
    output logic        ALUSrc_o,
    output logic        MemtoReg_o,
    output logic        RegWrite_o,
    output logic        Branch_o,
    output logic [1:0]  ALUOp_o,
    output logic        illegal_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_o
);

    typedef enum logic [2:0] {S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB} state_e;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    state_e     state_q, state_d;
    logic [6:0] op_q;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) ||
               (op == OP_ST) || (op == OP_BR);
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_IF;
            S_IF:   if (mem_ack_i) state_d = S_ID;
            S_ID:   state_d = is_legal(opcode_i) ? S_EX : S_IF;
            S_EX: begin
                if (op_q == OP_R || op_q == OP_I)        state_d = S_WB;
                else if (op_q == OP_LD || op_q == OP_ST) state_d = S_MEM;
                else                                     state_d = S_IF;
            end
            S_MEM:  if (mem_ack_i) state_d = (op_q == OP_LD) ? S_WB : S_IF;
            S_WB:   state_d = S_IF;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) op_q <= opcode_i;
        end
    end

    // Controls are a pure decode of state/op_q, so reset clears them without a clock.
    // Exceptions: the IF ack cycle qualifies IRWrite/PCWrite, and ID flags illegal
    // from opcode_i because op_q is only being loaded in that cycle.
    always_comb begin
        mem_req_o  = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        PCWrite_o  = 1'b0;
        IRWrite_o  = 1'b0;
        ALUSrc_o   = 1'b0;
        MemtoReg_o = 1'b0;
        RegWrite_o = 1'b0;
        Branch_o   = 1'b0;
        ALUOp_o    = 2'b00;
        illegal_o  = 1'b0;
        case (state_q)
            S_IF: begin
                mem_req_o = 1'b1;
                MemRead_o = 1'b1;
                IRWrite_o = mem_ack_i;
                PCWrite_o = mem_ack_i;
            end
            S_ID: illegal_o = !is_legal(opcode_i);
            S_EX: begin
                if (op_q == OP_R) begin
                    ALUOp_o = 2'b10;
                end else if (op_q == OP_I) begin
                    ALUSrc_o = 1'b1;
                    ALUOp_o  = 2'b11;
                end else if (op_q == OP_LD || op_q == OP_ST) begin
                    ALUSrc_o = 1'b1;
                end else if (op_q == OP_BR) begin
                    ALUOp_o  = 2'b01;
                    Branch_o = 1'b1;
                end
            end
            S_MEM: begin
                mem_req_o  = 1'b1;
                MemRead_o  = (op_q == OP_LD);
                MemWrite_o = (op_q == OP_ST);
            end
            S_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = (op_q == OP_LD);
            end
            default: ;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [31:0] cyc_q, ret_q;
    logic        retire;

    assign retire = (state_q == S_WB) ||
                    (state_q == S_MEM && op_q == OP_ST && mem_ack_i) ||
                    (state_q == S_EX  && op_q == OP_BR);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_IDLE) cyc_q <= cyc_q + 32'd1;
            if (retire)            ret_q <= ret_q + 32'd1;
        end
    end

    assign cycle_cnt_o = cyc_q;
    assign instret_o   = ret_q;
`else
    assign cycle_cnt_o = 32'd0;
    assign instret_o   = 32'd0;
`endif

endmodule
